// File: rtl/input_sync_debounce_if.sv
// input_sync_debounce_if: level-in / conditioned-level-out bundle for the
// input conditioner. master = producer of D_in (and consumer of outputs),
// slave = the conditioner itself.
interface input_sync_debounce_if #(
    parameter int CNT_W = 8
);
    logic             D_in;
    logic             count_clr;
    logic             Q;
    logic             rise;
    logic             fall;
    logic [CNT_W-1:0] event_count;
    logic [7:0]       glitch_count;

    modport master (
        output D_in, count_clr,
        input  Q, rise, fall, event_count, glitch_count
    );

    modport slave (
        input  D_in, count_clr,
        output Q, rise, fall, event_count, glitch_count
    );
endinterface

// File: rtl/input_sync_debounce.sv
// input_sync_debounce: synchroniser chain + debounce filter feeding the
// d_ff / d_ff1 storage stages. Emits a clean registered level Q, one-cycle
// rise/fall pulses and a modulo rising-edge count.
// Optional macro DEBOUNCE_GLITCH_LOG_EN: adds a saturating count of bounces
// rejected by the filter; otherwise glitch_count is tied to zero.
module input_sync_debounce #(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int CNT_W           = 8
) (
    input  logic                  CLK,
    input  logic                  n_Reset,
    input_sync_debounce_if.slave  bus
);
    localparam int             CW       = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam logic [CW-1:0]  CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    typedef enum logic {STABLE, FILTER} state_t;

    logic [SYNC_STAGES-1:0] sync_pipe;
    logic                   sync_out;
    state_t                 state;
    logic [CW-1:0]          cnt;
    logic                   q_r, rise_r, fall_r;
    logic [CNT_W-1:0]       ev_r;
    logic                   take;

    assign sync_out = sync_pipe[SYNC_STAGES-1];

    // Plain flop chain; stage 1 is the only flop that sees the async level.
    always_ff @(posedge CLK) begin
        if (!n_Reset) sync_pipe <= '0;
        else          sync_pipe <= {sync_pipe[SYNC_STAGES-2:0], bus.D_in};
    end

    // Qualify a new level: immediate when the filter is one cycle long,
    // otherwise after the mismatch has persisted through the full count.
    always_comb begin
        take = 1'b0;
        if (sync_out != q_r) begin
            if (state == STABLE) take = (DEBOUNCE_CYCLES == 1);
            else                 take = (cnt == CNT_LAST);
        end
    end

    // Filter FSM: STABLE waits for a mismatch, FILTER counts its persistence.
    always_ff @(posedge CLK) begin
        if (!n_Reset) begin
            state <= STABLE;
            cnt   <= '0;
        end else begin
            case (state)
                STABLE: begin
                    cnt <= '0;
                    if (sync_out != q_r && !take) begin
                        state <= FILTER;
                        cnt   <= CW'(1);
                    end
                end
                FILTER: begin
                    if (sync_out == q_r || take) begin
                        state <= STABLE;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                default: begin
                    state <= STABLE;
                    cnt   <= '0;
                end
            endcase
        end
    end

    // Output level and edge pulses, all updated on the qualifying edge.
    always_ff @(posedge CLK) begin
        if (!n_Reset) begin
            q_r    <= 1'b0;
            rise_r <= 1'b0;
            fall_r <= 1'b0;
        end else begin
            rise_r <= take &  sync_out;
            fall_r <= take & ~sync_out;
            if (take) q_r <= sync_out;
        end
    end

    // Rising-edge event counter; clear beats a coincident rise.
    always_ff @(posedge CLK) begin
        if (!n_Reset || bus.count_clr) ev_r <= '0;
        else if (take && sync_out)     ev_r <= ev_r + CNT_W'(1);
    end

    assign bus.Q           = q_r;
    assign bus.rise        = rise_r;
    assign bus.fall        = fall_r;
    assign bus.event_count = ev_r;

`ifdef DEBOUNCE_GLITCH_LOG_EN
    logic       reject;
    logic [7:0] glitch_r;

    // A bounce is rejected when FILTER sees the input agree with Q again.
    assign reject = (state == FILTER) && (sync_out == q_r);

    // Saturating rejected-bounce counter.
    always_ff @(posedge CLK) begin
        if (!n_Reset || bus.count_clr)      glitch_r <= 8'h00;
        else if (reject && glitch_r != 8'hFF) glitch_r <= glitch_r + 8'h01;
    end

    assign bus.glitch_count = glitch_r;
`else
    assign bus.glitch_count = 8'h00;
`endif

endmodule

// File: tb/tb_input_sync_debounce.sv
// Scoreboard bench: two conditioners (defaults, and a 3-stage/1-cycle/2-bit
// variant). Each driven cycle steps a behavioural model and queues the
// expected post-edge outputs; a monitor pops and compares after each posedge.
module tb_input_sync_debounce;
    logic CLK = 1'b0;
    always #5 CLK = ~CLK;

    logic rst_a, rst_b;
    input_sync_debounce_if #(.CNT_W(8)) bus_a ();
    input_sync_debounce_if #(.CNT_W(2)) bus_b ();

    input_sync_debounce #(.SYNC_STAGES(2), .DEBOUNCE_CYCLES(4), .CNT_W(8)) dut_a (
        .CLK(CLK), .n_Reset(rst_a), .bus(bus_a));
    input_sync_debounce #(.SYNC_STAGES(3), .DEBOUNCE_CYCLES(1), .CNT_W(2)) dut_b (
        .CLK(CLK), .n_Reset(rst_b), .bus(bus_b));

    typedef struct { logic q; logic rise; logic fall; logic [7:0] ev; logic [7:0] gl; } exp_t;
    typedef struct { logic [7:0] sh; logic q; int run; logic rise; logic fall;
                     logic [7:0] ev; logic [7:0] gl; } mdl_t;

    exp_t qa[$], qb[$];
    mdl_t ma, mb;
    exp_t ea, eb;
    int   total = 0, bad = 0;
    logic a_rn = 0, a_d = 0, a_clr = 0, b_rn = 0, b_d = 0, b_clr = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference: history of raw samples, run length of sync/Q disagreement.
    function automatic mdl_t mdl_step(mdl_t m, logic rn, logic d, logic clr,
                                      int stages, int deb, int cntw);
        mdl_t n = m;
        logic s;
        if (!rn) begin
            n.sh = '0; n.q = 0; n.run = 0; n.rise = 0; n.fall = 0; n.ev = '0; n.gl = '0;
            return n;
        end
        s      = m.sh[stages-1];
        n.sh   = {m.sh[6:0], d};
        n.rise = 0;
        n.fall = 0;
        if (s != m.q) begin
            if (m.run + 1 >= deb) begin
                n.q = s; n.run = 0; n.rise = s; n.fall = !s;
            end else begin
                n.run = m.run + 1;
            end
        end else begin
`ifdef DEBOUNCE_GLITCH_LOG_EN
            if (m.run > 0 && m.gl != 8'hFF) n.gl = m.gl + 8'h01;
`endif
            n.run = 0;
        end
        if (clr) begin
            n.ev = '0;
            n.gl = '0;
        end else if (n.rise) begin
            n.ev = 8'((int'(m.ev) + 1) & ((1 << cntw) - 1));
        end
        return n;
    endfunction

    function automatic exp_t to_exp(mdl_t m);
        exp_t e;
        e.q = m.q; e.rise = m.rise; e.fall = m.fall; e.ev = m.ev; e.gl = m.gl;
        return e;
    endfunction

    // Drive one cycle on the negedge and queue what the next posedge must yield.
    task automatic tick();
        @(negedge CLK);
        rst_a = a_rn; bus_a.D_in = a_d; bus_a.count_clr = a_clr;
        rst_b = b_rn; bus_b.D_in = b_d; bus_b.count_clr = b_clr;
        ma = mdl_step(ma, a_rn, a_d, a_clr, 2, 4, 8);
        mb = mdl_step(mb, b_rn, b_d, b_clr, 3, 1, 2);
        qa.push_back(to_exp(ma));
        qb.push_back(to_exp(mb));
    endtask

    task automatic ta(input logic rn, input logic d, input logic clr, input int n);
        a_rn = rn; a_d = d; a_clr = clr;
        repeat (n) tick();
    endtask

    task automatic tb(input logic rn, input logic d, input logic clr, input int n);
        b_rn = rn; b_d = d; b_clr = clr;
        repeat (n) tick();
    endtask

    // Monitor: compare one queued expectation per DUT after every posedge.
    always @(posedge CLK) begin
        #1;
        if (qa.size() > 0) begin
            ea = qa.pop_front();
            chk("a_q",    32'(bus_a.Q),            32'(ea.q));
            chk("a_rise", 32'(bus_a.rise),         32'(ea.rise));
            chk("a_fall", 32'(bus_a.fall),         32'(ea.fall));
            chk("a_ev",   32'(bus_a.event_count),  32'(ea.ev));
            chk("a_gl",   32'(bus_a.glitch_count), 32'(ea.gl));
        end
        if (qb.size() > 0) begin
            eb = qb.pop_front();
            chk("b_q",    32'(bus_b.Q),            32'(eb.q));
            chk("b_rise", 32'(bus_b.rise),         32'(eb.rise));
            chk("b_fall", 32'(bus_b.fall),         32'(eb.fall));
            chk("b_ev",   32'(bus_b.event_count),  32'(eb.ev[1:0]));
            chk("b_gl",   32'(bus_b.glitch_count), 32'(eb.gl));
        end
    end

    initial begin
        ma = '{sh: '0, q: 0, run: 0, rise: 0, fall: 0, ev: '0, gl: '0};
        mb = ma;
        // DUT A scenarios (DUT B held in reset meanwhile)
        ta(0, 1, 0, 2);                       // reset with D_in high
        ta(1, 1, 0, 8);                       // requalify: Q at 6th edge
        ta(1, 0, 0, 8);                       // fall, count unchanged
        ta(1, 1, 0, 2); ta(1, 0, 0, 1);       // bounce 2 high / 1 low
        ta(1, 1, 0, 3); ta(1, 0, 0, 8);       // 3 high then low
        ta(1, 1, 0, 8); ta(1, 1, 1, 1);       // clean rise, then clear
        ta(1, 1, 0, 2);
        ta(1, 0, 0, 8);
        ta(1, 1, 0, 3); ta(0, 1, 0, 1);       // reset at 4th edge of filter
        ta(1, 1, 0, 8);                       // full-latency requalify
        for (int i = 0; i < 30; i++)
            ta(1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 9) == 0), $urandom_range(1, 7));
        // DUT B scenarios (DUT A idles)
        a_clr = 0;
        tb(0, 0, 0, 2);
        tb(1, 1, 0, 6);                       // step: Q at edge 4
        tb(1, 0, 0, 6);
        tb(1, 1, 0, 1); tb(1, 0, 0, 6);       // one-cycle pulse passes
        for (int i = 0; i < 6; i++) begin     // wrap of 2-bit count
            tb(1, 1, 0, 2); tb(1, 0, 0, 2);
        end
        tb(1, 0, 0, 5);
        tb(1, 1, 0, 3); tb(1, 1, 1, 1);       // clear coincides with rise
        tb(1, 1, 0, 3);
        for (int i = 0; i < 60; i++)
            tb(1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 4) == 0), 1);
        @(posedge CLK);
        #2;
        chk("a_drain", 32'(qa.size()), 32'd0);
        chk("b_drain", 32'(qb.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
